reorder_buffer_nwb: RTL

In-order reorder buffer with a parametrised number of writeback channels. It allocates entries from the issue stage and accepts out-of-order results from WB_PORTS producers (ALUs, load unit), forwarding them to the issue stage in the same cycle. It commits one entry per cycle to the register file, load/store buffer and branch predictor. Branch metadata is kept in dedicated per-entry fields, so mispredict recovery supplies a full 32-bit correct PC.

---
 rtl/reorder_buffer_nwb.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer_nwb.sv
// In-order reorder buffer with WB_PORTS out-of-order writeback channels,
// same-cycle operand bypass and one registered commit per cycle.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global stall when low)
//   issue_*        : allocate one entry at the tail (rob_tag = tail)
//   wb_valid/tag/value : packed per-port results, port p at slice p
//   rob_tag_rs1/2 -> rob_value_rs1/2, rob_ready_rs1/2 : operand lookup
//   reg_*, lsb_*, predictor_* : registered commit strobes and data
//   clear_signal/correct_pc   : one-cycle mispredict flush request
//   count, full, empty        : occupancy
module reorder_buffer_nwb #(
   parameter int ROB_WIDTH   = 4,
   parameter int ROB_SIZE    = 2**ROB_WIDTH,
   parameter int WB_PORTS    = 3,
   parameter int LOCAL_WIDTH = 6
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rdy_in,
   output logic                          clear_signal,
   output logic [31:0]                   correct_pc,
   input  logic                          issue_signal,
   input  logic [1:0]                    issue_opcode,
   input  logic                          issue_value_ready,
   input  logic [31:0]                   issue_value,
   input  logic [4:0]                    issue_rd_id,
   input  logic                          issue_pred_taken,
   input  logic [LOCAL_WIDTH-1:0]        issue_pred_addr,
   input  logic [31:0]                   issue_alt_pc,
   input  logic [WB_PORTS-1:0]           wb_valid,
   input  logic [WB_PORTS*ROB_WIDTH-1:0] wb_tag,
   input  logic [WB_PORTS*32-1:0]        wb_value,
   output logic                          reg_done,
   output logic [31:0]                   reg_value,
   output logic [4:0]                    reg_id,
   output logic [ROB_WIDTH-1:0]          reg_tag,
   output logic                          lsb_done,
   output logic [ROB_WIDTH-1:0]          lsb_tag,
   output logic                          predictor_signal,
   output logic                          predictor_branch,
   output logic [LOCAL_WIDTH-1:0]        predictor_addr,
   output logic [ROB_WIDTH-1:0]          rob_tag,
   input  logic [ROB_WIDTH-1:0]          rob_tag_rs1,
   input  logic [ROB_WIDTH-1:0]          rob_tag_rs2,
   output logic [31:0]                   rob_value_rs1,
   output logic [31:0]                   rob_value_rs2,
   output logic                          rob_ready_rs1,
   output logic                          rob_ready_rs2,
   output logic [ROB_WIDTH:0]            count,
   output logic                          full,
   output logic                          empty
);

   typedef enum logic [1:0] {
      OP_REG    = 2'b00,
      OP_STORE  = 2'b01,
      OP_BRANCH = 2'b10,
      OP_LOAD   = 2'b11
   } op_t;

   localparam int unsigned SIZE_U = ROB_SIZE;
   localparam logic [ROB_WIDTH:0] SIZE_C = SIZE_U[ROB_WIDTH:0];
   localparam logic [ROB_WIDTH:0] ONE_C  = {{ROB_WIDTH{1'b0}}, 1'b1};

   logic [ROB_SIZE-1:0]    busy_q;
   logic [ROB_SIZE-1:0]    ready_q;
   logic [ROB_SIZE-1:0]    pt_q;
   logic [31:0]            value_q [ROB_SIZE];
   logic [4:0]             rd_q    [ROB_SIZE];
   op_t                    op_q    [ROB_SIZE];
   logic [LOCAL_WIDTH-1:0] paddr_q [ROB_SIZE];
   logic [31:0]            alt_q   [ROB_SIZE];
   logic [ROB_WIDTH-1:0]   head;
   logic [ROB_WIDTH-1:0]   tail;

   logic [ROB_WIDTH-1:0]   wtag [WB_PORTS];
   logic [31:0]            wval [WB_PORTS];
   logic                   issue_ok;
   logic                   commit_ok;
   logic                   hit1, hit2;
   logic [31:0]            fwd1, fwd2;

   assign issue_ok  = issue_signal && (count != SIZE_C);
   assign commit_ok = busy_q[head] && ready_q[head];
   assign rob_tag   = tail;
   assign empty     = (count == '0);
   assign full      = (count == SIZE_C) ||
                      ((count == SIZE_C - ONE_C) && issue_signal);

   // Unpack the channels; lookup scans high to low so port 0 wins.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      fwd1 = '0;
      fwd2 = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         wtag[p] = wb_tag[p*ROB_WIDTH +: ROB_WIDTH];
         wval[p] = wb_value[p*32 +: 32];
      end
      for (int p = WB_PORTS-1; p >= 0; p--) begin
         if (wb_valid[p] && wtag[p] == rob_tag_rs1) begin
            hit1 = 1'b1;
            fwd1 = wval[p];
         end
         if (wb_valid[p] && wtag[p] == rob_tag_rs2) begin
            hit2 = 1'b1;
            fwd2 = wval[p];
         end
      end
      rob_ready_rs1 = busy_q[rob_tag_rs1] & (ready_q[rob_tag_rs1] | hit1);
      rob_ready_rs2 = busy_q[rob_tag_rs2] & (ready_q[rob_tag_rs2] | hit2);
      rob_value_rs1 = hit1 ? fwd1 : value_q[rob_tag_rs1];
      rob_value_rs2 = hit2 ? fwd2 : value_q[rob_tag_rs2];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q           <= '0;
         ready_q          <= '0;
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         clear_signal     <= 1'b0;
         correct_pc       <= '0;
         reg_done         <= 1'b0;
         reg_value        <= '0;
         reg_id           <= '0;
         reg_tag          <= '0;
         lsb_done         <= 1'b0;
         lsb_tag          <= '0;
         predictor_signal <= 1'b0;
         predictor_branch <= 1'b0;
         predictor_addr   <= '0;
      end else if (rdy_in) begin
         reg_done         <= 1'b0;
         lsb_done         <= 1'b0;
         predictor_signal <= 1'b0;
         clear_signal     <= 1'b0;
         if (clear_signal) begin
            busy_q  <= '0;
            ready_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
         end else begin
            if (issue_ok) begin
               busy_q[tail]  <= 1'b1;
               ready_q[tail] <= issue_value_ready;
               value_q[tail] <= issue_value;
               rd_q[tail]    <= issue_rd_id;
               op_q[tail]    <= op_t'(issue_opcode);
               pt_q[tail]    <= issue_pred_taken;
               paddr_q[tail] <= issue_pred_addr;
               alt_q[tail]   <= issue_alt_pc;
               tail          <= tail + 1'b1;
            end
            // Descending order: the lowest port's write lands last.
            for (int p = WB_PORTS-1; p >= 0; p--) begin
               if (wb_valid[p] && busy_q[wtag[p]] && !ready_q[wtag[p]]) begin
                  ready_q[wtag[p]] <= 1'b1;
                  value_q[wtag[p]] <= (op_q[wtag[p]] == OP_BRANCH) ?
                                      {31'b0, wval[p][0]} : wval[p];
               end
            end
            if (commit_ok) begin
               busy_q[head]  <= 1'b0;
               ready_q[head] <= 1'b0;
               head          <= head + 1'b1;
               unique case (op_q[head])
                  OP_REG: begin
                     reg_done  <= 1'b1;
                     reg_value <= value_q[head];
                     reg_id    <= rd_q[head];
                     reg_tag   <= head;
                  end
                  OP_STORE: begin
                     lsb_done <= 1'b1;
                     lsb_tag  <= head;
                  end
                  OP_LOAD: begin
                     reg_done  <= 1'b1;
                     reg_value <= value_q[head];
                     reg_id    <= rd_q[head];
                     reg_tag   <= head;
                     lsb_done  <= 1'b1;
                     lsb_tag   <= head;
                  end
                  OP_BRANCH: begin
                     predictor_signal <= 1'b1;
                     predictor_branch <= value_q[head][0];
                     predictor_addr   <= paddr_q[head];
                     if (value_q[head][0] != pt_q[head]) begin
                        clear_signal <= 1'b1;
                        correct_pc   <= alt_q[head];
                     end
                  end
               endcase
            end
            if (issue_ok && !commit_ok)
               count <= count + ONE_C;
            else if (!issue_ok && commit_ok)
               count <= count - ONE_C;
         end
      end
   end

endmodule
